epass_lane_arbiter: RTL
=======================

// Module: epass_lane_arbiter
// PURPOSE
//  Shares one E-pass validation datapath between NUM_LANES toll lanes. Per-lane
//  controllers raise req when a vehicle is detected. This block grants one lane
//  at a time, starts the validator and bounds its run with a timeout. It then
//  returns a one-cycle pass/fail result to the granted lane.
// PARAMETERS
//  NUM_LANES    4   number of requesting lanes (>=2)
//  TIMEOUT_CYC  16  max cycles in WAIT before a forced fail (>=2)
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  reset_n      in   1          asynchronous, active-low reset
//  req          in   NUM_LANES  per-lane request; level held until that lane's res_valid
//  grant        out  NUM_LANES  one-hot, the lane currently served; 0 when idle
//  res_valid    out  NUM_LANES  one-cycle pulse on the served lane: result ready
//  res_ok       out  1          E-pass accepted; qualified by |res_valid
//  res_timeout  out  1          validator did not answer in time; qualified by |res_valid
//  val_start    out  1          one-cycle pulse: validator begins on val_lane
//  val_lane     out  LANE_W     index of the served lane; LANE_W = max(1,$clog2(NUM_LANES))
//  val_done     in   1          validator finished (single-cycle pulse)
//  val_ok       in   1          validator verdict; sampled only with val_done
//  busy         out  1          high whenever state != IDLE
// BEHAVIOUR
//  - All outputs are registered. On reset: state=IDLE; grant, res_valid, res_ok,
//    res_timeout, val_start, val_lane, busy and the timer are all 0; rr_ptr=0.
//  - FSM states:
//    IDLE:  if |req, pick a winner (round-robin from rr_ptr). Load grant and
//           val_lane. Go to START.
//    START: val_start=1 for exactly this cycle. Load timer=0. Go to WAIT.
//           A val_done in this cycle is ignored.
//    WAIT:  if val_done: latch ok=val_ok, tmo=0, go to RESP.
//           Else if timer==TIMEOUT_CYC-1: ok=0, tmo=1, go to RESP.
//           Else timer++.
//    RESP:  res_valid[g]=1, res_ok=ok, res_timeout=tmo for one cycle.
//           rr_ptr = (g+1) mod NUM_LANES. Clear grant. Go to IDLE.
//  - Latency:
//    req seen in IDLE at cycle c -> grant and val_start at c+1.
//    val_done at cycle k -> res_valid at k+1.
//    Minimum back-to-back spacing is 4 cycles/grant.
//  - Round-robin rule: search lanes rr_ptr, rr_ptr+1, ... and wrap at NUM_LANES.
//    The first lane with req high wins. No lane is starved: max wait is
//    NUM_LANES-1 grants.
//  - A lane that drops req mid-transaction is not cancelled. Its result is still
//    pulsed and the lane ignores it.
//  - val_done while in IDLE or RESP is ignored. val_ok is don't-care without val_done.
//  - val_done in the same cycle as the timeout: val_done wins (ok=val_ok, tmo=0).
//  - Simultaneous new req and res_valid: a lane whose res_valid is high must not
//    be re-granted in the next IDLE cycle unless its req is still high.
//  - reset_n low mid-WAIT: everything returns to reset values at once. No
//    res_valid is emitted for the aborted transaction.
// CONFIGURATION
//  EPASS_ARB_PRIORITY_EN defined:
//    - lane 0 is a priority lane: if req[0] is high in IDLE, it wins regardless
//      of rr_ptr.
//    - rr_ptr only advances on grants to lanes 1..NUM_LANES-1.
//  EPASS_ARB_PRIORITY_EN undefined: pure round-robin over all lanes.
// STRUCTURE
//  - Package epass_pkg:
//    - state encoding localparams/enum (IDLE, START, WAIT, RESP)
//    - function clog2_min1 for LANE_W
//    - shared default timeout constant
//  - Sub-module rr_pick:
//    - combinational; inputs req and rr_ptr, outputs a one-hot winner and its index
//    - also reused by the gate-actuator sharer
// TESTING (NUM_LANES=4, TIMEOUT_CYC=16)
//  1. req=0001, val_done+val_ok=1 three cycles after val_start
//     -> val_lane=0, then res_valid=0001, res_ok=1, res_timeout=0.
//  2. req=1111 held, validator answers ok each time
//     -> grants in order lane 0,1,2,3,0; each lane gets one res_valid pulse.
//  3. req=0100, val_done never asserted
//     -> res_valid=0100, res_ok=0, res_timeout=1 exactly 17 cycles after val_start.
//  4. val_done on the timeout cycle with val_ok=1
//     -> res_ok=1, res_timeout=0.
//  5. reset_n pulsed low in WAIT
//     -> all outputs 0 next edge, no res_valid; a fresh req=0010 is then served normally.
//  6. Macro defined, rr_ptr=2, req=0101
//     -> lane 0 granted first, lane 2 next; macro undefined -> lane 2 first.

Source files
------------

// File: rtl/epass_pkg.sv
// Shared definitions for the E-pass lane arbiter and related lane sharers:
// FSM state encoding, lane-index width helper and the default timeout.
package epass_pkg;

    // Arbiter FSM states; the encoding is also exported on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Validator cycles allowed in WAIT before a forced fail.
    localparam int DEFAULT_TIMEOUT_CYC = 16;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/epass_lane_arbiter_rr_pick.sv
// Combinational round-robin picker: scans lanes starting at rr_ptr, wrapping at
// N, and reports the first requesting lane as one-hot and as an index.
// Also used by the gate-actuator sharer.
module rr_pick
    import epass_pkg::*;
#(
    parameter  int N  = 4,
    localparam int LW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] rr_ptr,
    output logic [N-1:0]  win_onehot,
    output logic [LW-1:0] win_idx,
    output logic          win_any
);

    // First requester at or after rr_ptr, in circular order.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!win_any && req[(int'(rr_ptr) + i) % N]) begin
                win_any                              = 1'b1;
                win_idx                              = LW'((int'(rr_ptr) + i) % N);
                win_onehot[(int'(rr_ptr) + i) % N]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/epass_lane_arbiter.sv
// E-pass lane arbiter: shares one validator between NUM_LANES toll lanes.
// Grants one lane at a time, pulses val_start, bounds the validator run with a
// timeout and returns a one-cycle pass/fail result to the served lane.
// Optional build macro EPASS_ARB_PRIORITY_EN makes lane 0 a priority lane that
// wins whenever it requests and does not move the round-robin pointer.
//
// Handshake: a lane raises req and holds it until it sees its res_valid bit.
// grant is one-hot for the lane in service (zero when idle). res_valid is a
// single-cycle pulse on that lane; res_ok/res_timeout are only meaningful while
// |res_valid. Toward the validator, val_start is a single-cycle pulse on
// val_lane and val_done is a single-cycle pulse carrying val_ok.
module epass_lane_arbiter
    import epass_pkg::*;
#(
    parameter  int NUM_LANES   = 4,
    parameter  int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    localparam int LANE_W      = clog2_min1(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_LANES-1:0] req,
    output logic [NUM_LANES-1:0] grant,
    output logic [NUM_LANES-1:0] res_valid,
    output logic                 res_ok,
    output logic                 res_timeout,
    output logic                 val_start,
    output logic [LANE_W-1:0]    val_lane,
    input  logic                 val_done,
    input  logic                 val_ok,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    localparam int              TMR_W   = clog2_min1(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    arb_state_t           state;
    logic [TMR_W-1:0]     timer;
    logic [LANE_W-1:0]    rr_ptr;

    logic [NUM_LANES-1:0] rr_onehot;
    logic [LANE_W-1:0]    rr_idx;
    logic                 rr_any;

    logic [NUM_LANES-1:0] pick_onehot;
    logic [LANE_W-1:0]    pick_idx;
    logic                 pick_any;
    logic [LANE_W-1:0]    rr_next;
    logic                 rr_adv;

    rr_pick #(.N(NUM_LANES)) u_rr_pick (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .win_onehot (rr_onehot),
        .win_idx    (rr_idx),
        .win_any    (rr_any)
    );

`ifdef EPASS_ARB_PRIORITY_EN
    // Lane 0 pre-empts the round-robin choice; only other lanes move the pointer.
    always_comb begin
        pick_onehot = rr_onehot;
        pick_idx    = rr_idx;
        pick_any    = rr_any;
        if (req[0]) begin
            pick_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1};
            pick_idx    = '0;
            pick_any    = 1'b1;
        end
        rr_adv = (val_lane != '0);
    end
`else
    // Pure round-robin over all lanes.
    always_comb begin
        pick_onehot = rr_onehot;
        pick_idx    = rr_idx;
        pick_any    = rr_any;
        rr_adv      = 1'b1;
    end
`endif

    // Pointer to the lane after the one being served, wrapping at NUM_LANES.
    always_comb begin
        rr_next = (val_lane == LAST_LANE) ? '0 : val_lane + 1'b1;
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            res_valid   <= '0;
            res_ok      <= 1'b0;
            res_timeout <= 1'b0;
            val_start   <= 1'b0;
            val_lane    <= '0;
            busy        <= 1'b0;
            timer       <= '0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant     <= pick_onehot;
                        val_lane  <= pick_idx;
                        val_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    // A val_done seen here belongs to nothing we started; drop it.
                    val_start <= 1'b0;
                    timer     <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real answer beats a coincident timeout.
                    if (val_done) begin
                        res_valid   <= grant;
                        res_ok      <= val_ok;
                        res_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else if (timer == TMR_MAX) begin
                        res_valid   <= grant;
                        res_ok      <= 1'b0;
                        res_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESP: begin
                    res_valid   <= '0;
                    res_ok      <= 1'b0;
                    res_timeout <= 1'b0;
                    grant       <= '0;
                    busy        <= 1'b0;
                    if (rr_adv) begin
                        rr_ptr <= rr_next;
                    end
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
